divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 158 +++++++++++++++
 tb/tb_divider.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// Module  : divider
// Purpose : Sequential restoring divider. It divides a 2W-bit dividend by a
//           W-bit divisor and produces one quotient bit per clock. Divide by
//           zero and quotient overflow skip the iteration and raise err.
// Option  : DIVIDER_STICKY_DONE_EN keeps done high until the next accepted start.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module divider #(
   parameter int DATAWIDTH = 14
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [2*DATAWIDTH-1:0]   dividend,
   input  logic [DATAWIDTH-1:0]     divisor,
   output logic                     busy,
   output logic                     done,
   output logic [DATAWIDTH-1:0]     quotient,
   output logic [DATAWIDTH-1:0]     remainder,
   output logic                     err
);

   localparam int W  = DATAWIDTH;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  prem_q, prem_d;
   logic [W-1:0]  low_q, low_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  quotient_q, quotient_d;
   logic [W-1:0]  remainder_q, remainder_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          accept;
   logic          bad_op;
   logic [W:0]    shifted;
   logic          ge;
   logic [W-1:0]  diff;
   logic [W-1:0]  prem_next;
   logic [W-1:0]  quo_next;

   assign accept  = start && (state_q != RUN);
   // A high half at or above the divisor cannot give a W-bit quotient.
   assign bad_op  = (divisor == '0) || (dividend[2*W-1:W] >= divisor);

   assign shifted   = {prem_q, low_q[W-1]};
   assign ge        = (shifted >= {1'b0, dvs_q});
   assign diff      = shifted[W-1:0] - dvs_q;
   assign prem_next = ge ? diff : shifted[W-1:0];
   assign quo_next  = {quo_q[W-2:0], ge};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prem_d      = prem_q;
      low_d       = low_q;
      dvs_d       = dvs_q;
      quo_d       = quo_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      busy_d      = busy_q;
      err_d       = err_q;
`ifdef DIVIDER_STICKY_DONE_EN
      done_d      = done_q;
`else
      done_d      = 1'b0;
`endif
      case (state_q)
         RUN: begin
            prem_d = prem_next;
            quo_d  = quo_next;
            low_d  = {low_q[W-2:0], 1'b0};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d     = DONE;
               cnt_d       = '0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               err_d       = 1'b0;
               quotient_d  = quo_next;
               remainder_d = prem_next;
            end
         end
         default: begin
            state_d = IDLE;
            if (accept) begin
               done_d = 1'b0;
               if (bad_op) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  err_d       = 1'b1;
                  quotient_d  = '1;
                  remainder_d = '0;
               end else begin
                  state_d = RUN;
                  busy_d  = 1'b1;
                  prem_d  = dividend[2*W-1:W];
                  low_d   = dividend[W-1:0];
                  dvs_d   = divisor;
                  quo_d   = '0;
                  cnt_d   = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         prem_q      <= '0;
         low_q       <= '0;
         dvs_q       <= '0;
         quo_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prem_q      <= prem_d;
         low_q       <= low_d;
         dvs_q       <= dvs_d;
         quo_q       <= quo_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// Module  : tb_divider
// Purpose : Directed self-checking bench for divider (DATAWIDTH = 14).
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_divider;

   localparam int W = 14;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [2*W-1:0] dividend;
   logic [W-1:0]   divisor;
   logic           busy;
   logic           done;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic           err;

   int pass_cnt;
   int chk_cnt;

   divider #(.DATAWIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present operands at a falling edge; returns #1 after the accepting edge.
   task automatic launch(input logic [2*W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Edge index counts the accepting edge as 1. edges = -1 if done never rose.
   task automatic wait_done(input int idx0, output int edges, output int busy_n,
                            output logic held);
      logic [W-1:0] q0;
      logic [W-1:0] r0;
      q0     = quotient;
      r0     = remainder;
      held   = 1'b1;
      edges  = idx0;
      busy_n = busy ? 1 : 0;
      while (!done && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
         if (busy) busy_n++;
         if (!done && (quotient !== q0 || remainder !== r0)) held = 1'b0;
      end
      if (!done) edges = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_cnt++;
      if ({busy, done, err, quotient, remainder} !== '0) begin
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b q=%0d r=%0d, want all 0",
                  busy, done, err, quotient, remainder);
      end else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int e, b;
      logic h;
      launch(28'd1020, 14'd4);
      wait_done(1, e, b, h);
      chk_cnt++;
      if (e !== 15) $display("FAIL basic_latency: got %0d edges, want 15", e);
      else pass_cnt++;
      chk_cnt++;
      if (b !== 14) $display("FAIL basic_busy_cycles: got %0d, want 14", b);
      else pass_cnt++;
      chk_cnt++;
      if (h !== 1'b1 || quotient !== 14'd255 || remainder !== 14'd0 || err !== 1'b0)
         $display("FAIL basic_result: got held=%b q=%0d r=%0d err=%b, want held=1 q=255 r=0 err=0",
                  h, quotient, remainder, err);
      else pass_cnt++;
      @(posedge clk);
      #1;
      chk_cnt++;
`ifdef DIVIDER_STICKY_DONE_EN
      if (done !== 1'b1 || busy !== 1'b0)
         $display("FAIL basic_after_done: got done=%b busy=%b, want done=1 busy=0", done, busy);
`else
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL basic_after_done: got done=%b busy=%b, want done=0 busy=0", done, busy);
`endif
      else pass_cnt++;
      chk_cnt++;
      if (quotient !== 14'd255 || remainder !== 14'd0)
         $display("FAIL basic_hold: got q=%0d r=%0d, want q=255 r=0", quotient, remainder);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int e, b;
      logic h;
      launch(28'd1023, 14'd4);
      wait_done(1, e, b, h);
      chk_cnt++;
      if (e !== 15 || quotient !== 14'd255 || remainder !== 14'd3 || err !== 1'b0)
         $display("FAIL b2b_first: got edges=%0d q=%0d r=%0d err=%b, want 15 255 3 0",
                  e, quotient, remainder, err);
      else pass_cnt++;
      dividend = 28'd268402687;
      divisor  = 14'd16383;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk_cnt++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", busy, done);
      else pass_cnt++;
      wait_done(1, e, b, h);
      chk_cnt++;
      if (e !== 15 || h !== 1'b1 || quotient !== 14'd16382 || remainder !== 14'd16381 || err !== 1'b0)
         $display("FAIL b2b_second: got edges=%0d held=%b q=%0d r=%0d err=%b, want 15 1 16382 16381 0",
                  e, h, quotient, remainder, err);
      else pass_cnt++;
   endtask

   task automatic test_errors();
      int e, b;
      logic h;
      launch(28'd5000, 14'd0);
      wait_done(1, e, b, h);
      chk_cnt++;
      if (e !== 1 || b !== 0 || err !== 1'b1 || quotient !== 14'd16383 || remainder !== 14'd0)
         $display("FAIL div_by_zero: got edges=%0d busy_n=%0d err=%b q=%0d r=%0d, want 1 0 1 16383 0",
                  e, b, err, quotient, remainder);
      else pass_cnt++;
      @(posedge clk);
      #1;
      launch(28'd65536, 14'd4);
      wait_done(1, e, b, h);
      chk_cnt++;
      if (e !== 1 || b !== 0 || err !== 1'b1 || quotient !== 14'd16383 || remainder !== 14'd0)
         $display("FAIL overflow: got edges=%0d busy_n=%0d err=%b q=%0d r=%0d, want 1 0 1 16383 0",
                  e, b, err, quotient, remainder);
      else pass_cnt++;
      launch(28'd200000, 14'd300);
      wait_done(1, e, b, h);
      chk_cnt++;
      if (e !== 15 || err !== 1'b0 || quotient !== 14'd666 || remainder !== 14'd200)
         $display("FAIL err_clear: got edges=%0d err=%b q=%0d r=%0d, want 15 0 666 200",
                  e, err, quotient, remainder);
      else pass_cnt++;
   endtask

   task automatic test_ignore_start();
      int e, b;
      logic h;
      launch(28'd5000, 14'd9);
      repeat (4) @(posedge clk);
      @(negedge clk);
      dividend = 28'd100;
      divisor  = 14'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(6, e, b, h);
      chk_cnt++;
      if (e !== 15 || quotient !== 14'd555 || remainder !== 14'd5 || err !== 1'b0)
         $display("FAIL ignore_start: got edges=%0d q=%0d r=%0d err=%b, want 15 555 5 0",
                  e, quotient, remainder, err);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_run();
      int e, b;
      logic h;
      logic saw_done;
      launch(28'd1020, 14'd7);
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({busy, done, err, quotient, remainder} !== '0)
         $display("FAIL reset_mid_run: got busy=%b done=%b err=%b q=%0d r=%0d, want all 0",
                  busy, done, err, quotient, remainder);
      else pass_cnt++;
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done || busy) saw_done = 1'b1;
      end
      chk_cnt++;
      if (saw_done !== 1'b0) $display("FAIL reset_no_done: got activity=%b, want 0", saw_done);
      else pass_cnt++;
      launch(28'd1000, 14'd7);
      wait_done(1, e, b, h);
      chk_cnt++;
      if (e !== 15 || quotient !== 14'd142 || remainder !== 14'd6 || err !== 1'b0)
         $display("FAIL after_reset: got edges=%0d q=%0d r=%0d err=%b, want 15 142 6 0",
                  e, quotient, remainder, err);
      else pass_cnt++;
   endtask

   task automatic test_done_idle();
      int high_n;
      high_n = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) high_n++;
      end
      chk_cnt++;
`ifdef DIVIDER_STICKY_DONE_EN
      if (high_n !== 20) $display("FAIL sticky_idle: got done high %0d cycles, want 20", high_n);
`else
      if (high_n !== 0) $display("FAIL pulse_idle: got done high %0d cycles, want 0", high_n);
`endif
      else pass_cnt++;
      launch(28'd77, 14'd5);
      chk_cnt++;
      if (done !== 1'b0 || busy !== 1'b1)
         $display("FAIL done_clear_on_accept: got done=%b busy=%b, want done=0 busy=1", done, busy);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt = 0;
      chk_cnt  = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_errors();
      test_ignore_start();
      test_reset_mid_run();
      test_done_idle();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

`default_nettype wire
